led_ctrl: RTL and testbench
===========================

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk_i cycles per prescaler tick; legal range 2..2^24.
REQ-002 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-003 SHALL have port reset_i, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port we_i, input, 1, write strobe, one write per asserted cycle.
REQ-005 SHALL have port addr_i, input, 2, register index: 0 DATA, 1 CTRL, 2 PERIOD, 3 STATUS.
REQ-006 SHALL have port wdata_i, input, 32, write data.
REQ-007 SHALL have port rdata_o, output, 32, combinational read of the register at addr_i; unused bits read 0.
REQ-008 SHALL have port leds_o, output, 16, LED drive.
REQ-009 SHALL have port step_o, output, 1, one-cycle pulse on every step event.

Function
REQ-010 DATA[15:0] SHALL hold the pattern; writes take wdata_i[15:0].
REQ-011 CTRL SHALL hold mode[1:0] (0 static, 1 blink, 2 rotate-left, 3 rotate-right) and enable[2]; writes take wdata_i[2:0].
REQ-012 PERIOD[15:0] SHALL hold ticks per step; value 0 SHALL behave as 1.
REQ-013 STATUS SHALL read {14'b0, phase, running, leds_o}; writes to STATUS SHALL be ignored.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 while enable=1; tick asserts in the cycle where the count is TICK_DIV-1, then the count wraps to 0.
REQ-015 A step counter SHALL advance on each tick; a step event SHALL occur on the tick where the counter equals max(PERIOD,1)-1, then the counter wraps to 0.
REQ-016 step_o SHALL be high exactly in the cycle the step event occurs.
REQ-017 The FSM SHALL have states IDLE and RUN: IDLE->RUN on the cycle after enable=1 is written; RUN->IDLE on the cycle after enable=0 is written; running=1 only in RUN.
REQ-018 In IDLE the prescaler, step counter and phase SHALL hold 0, and no step events occur.
REQ-019 A working register SHALL load DATA whenever DATA or CTRL is written, at that write's clock edge.
REQ-020 On each step event, mode 1 SHALL toggle phase; mode 2 SHALL rotate the working register left by 1 (bit15->bit0); mode 3 SHALL rotate it right by 1 (bit0->bit15); mode 0 SHALL change nothing.
REQ-021 leds_o SHALL be 0 in IDLE; in RUN: mode 0 = DATA, mode 1 = phase ? 0 : DATA, modes 2/3 = working register.
REQ-022 leds_o SHALL be combinational from registers, so a write is visible on leds_o the cycle after the write edge.
REQ-023 Any write to DATA, CTRL or PERIOD SHALL clear the prescaler, the step counter and phase.
REQ-024 If a write and a step event coincide, the write SHALL take precedence; the step's register update is discarded, but step_o still pulses.
REQ-025 A mode change via CTRL while in RUN SHALL take effect without leaving RUN.

Reset
REQ-026 On reset_i=1, DATA, CTRL, PERIOD, working register, prescaler, step counter and phase SHALL go to 0, and the FSM SHALL go to IDLE, immediately and independent of clk_i.
REQ-027 During and after reset, leds_o=0, step_o=0, and rdata_o shows zeros for all registers.
REQ-028 Reset asserted mid-step SHALL abort the step with no step_o pulse.

Verification (TICK_DIV=4)
REQ-029 Write DATA=0x00F0, CTRL=0x4 -> leds_o=0x00F0 the next cycle; no leds change thereafter; STATUS[16]=1.
REQ-030 DATA=0x8001, PERIOD=2, CTRL=0x6 -> step_o every 8 cycles; leds_o 0x8001 -> 0x0003 -> 0x0006.
REQ-031 DATA=0x0001, PERIOD=0, CTRL=0x7 -> step every 4 cycles; leds_o 0x0001 -> 0x8000 -> 0x4000.
REQ-032 DATA=0xAAAA, PERIOD=1, CTRL=0x5 -> leds_o alternates 0xAAAA/0x0000 every 4 cycles; write CTRL=0x1 -> leds_o=0, step_o silent.
REQ-033 Write DATA in the same cycle as a step event -> leds_o shows the new DATA unrotated; next step comes a full period later.
REQ-034 Assert reset_i asynchronously mid-period in rotate mode -> all outputs 0 at once; rdata_o=0 at every addr_i.

Source files
------------

// File: rtl/led_ctrl.sv
// LED pattern controller: DATA/CTRL/PERIOD registers drive a prescaled step engine (static, blink, rotate).
// leds_o and rdata_o are combinational from registers; a write is visible the cycle after its edge.
module led_ctrl #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [15:0] leds_o,
    output logic        step_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] period_q, period_d;
    logic [15:0] work_q, work_d;
    logic [23:0] presc_q, presc_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        phase_q, phase_d;

    logic        wr_data, wr_ctrl, wr_period, wr_any;
    logic        running, tick, step;
    logic [15:0] period_eff;
    logic        unused_wdata;

    assign unused_wdata = ^wdata_i[31:16];

    always_comb begin
        wr_data    = we_i && (addr_i == 2'd0);
        wr_ctrl    = we_i && (addr_i == 2'd1);
        wr_period  = we_i && (addr_i == 2'd2);
        wr_any     = wr_data || wr_ctrl || wr_period;
        running    = (state_q == RUN);
        period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
        tick       = running && (presc_q == PRESC_MAX);
        step       = tick && (step_cnt_q == period_eff - 16'd1);
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        work_d     = work_q;
        presc_d    = presc_q;
        step_cnt_d = step_cnt_q;
        phase_d    = phase_q;

        if (running) begin
            presc_d = tick ? 24'd0 : presc_q + 24'd1;
            if (tick) begin
                step_cnt_d = step ? 16'd0 : step_cnt_q + 16'd1;
            end
            if (step) begin
                case (ctrl_q[1:0])
                    2'd1:    phase_d = ~phase_q;
                    2'd2:    work_d  = {work_q[14:0], work_q[15]};
                    2'd3:    work_d  = {work_q[0], work_q[15:1]};
                    default: ;
                endcase
            end
        end else begin
            presc_d    = 24'd0;
            step_cnt_d = 16'd0;
            phase_d    = 1'b0;
        end

        // A register write restarts the timing and overrides any coincident step update.
        if (wr_any) begin
            presc_d    = 24'd0;
            step_cnt_d = 16'd0;
            phase_d    = 1'b0;
            work_d     = work_q;
        end
        if (wr_data) begin
            data_d = wdata_i[15:0];
            work_d = wdata_i[15:0];
        end
        if (wr_ctrl) begin
            ctrl_d  = wdata_i[2:0];
            work_d  = data_q;
            state_d = wdata_i[2] ? RUN : IDLE;
        end
        if (wr_period) begin
            period_d = wdata_i[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            data_q     <= 16'd0;
            ctrl_q     <= 3'd0;
            period_q   <= 16'd0;
            work_q     <= 16'd0;
            presc_q    <= 24'd0;
            step_cnt_q <= 16'd0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            work_q     <= work_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        leds_o = 16'd0;
        if (running) begin
            case (ctrl_q[1:0])
                2'd0:    leds_o = data_q;
                2'd1:    leds_o = phase_q ? 16'd0 : data_q;
                default: leds_o = work_q;
            endcase
        end
    end

    assign step_o = step;

    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            2'd0:    rdata_o = {16'd0, data_q};
            2'd1:    rdata_o = {29'd0, ctrl_q};
            2'd2:    rdata_o = {16'd0, period_q};
            default: rdata_o = {14'd0, phase_q, running, leds_o};
        endcase
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl with TICK_DIV=4: expectations are queued as stimulus is driven
// and compared at the following falling edge.
module tb_led_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        we_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic [15:0] leds_o;
    logic        step_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          chk;
        string       tag;
        logic [15:0] leds;
        logic        step;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    led_ctrl #(.TICK_DIV(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .leds_o  (leds_o),
        .step_o  (step_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rot(input logic [15:0] v, input int n, input bit left);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n % 16; i++) begin
            r = left ? {r[14:0], r[15]} : {r[0], r[15:1]};
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_leds(input logic [15:0] data, input logic [1:0] mode, input int n);
        case (mode)
            2'd0:    return data;
            2'd1:    return n[0] ? 16'd0 : data;
            2'd2:    return rot(data, n, 1'b1);
            default: return rot(data, n, 1'b0);
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
                chk({e.tag, ".leds"}, {16'd0, leds_o}, {16'd0, e.leds});
                chk({e.tag, ".step"}, {31'd0, step_o}, {31'd0, e.step});
                chk({e.tag, ".rdata"}, rdata_o, e.rd);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be during that cycle.
    task automatic cyc(input logic we, input logic [1:0] addr, input logic [31:0] wd, input bit c,
                       input string tag, input logic [15:0] leds, input logic step, input logic [31:0] rd);
        exp_t e;
        we_i = we;
        addr_i = addr;
        wdata_i = wd;
        e.chk = c;
        e.tag = tag;
        e.leds = leds;
        e.step = step;
        e.rd = rd;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    // setup: 0 = CTRL write only, 1 = stop then DATA/PERIOD/CTRL writes, 2 = no writes (timing already restarted)
    task automatic run_mode(input string tag, input logic [15:0] data, input logic [15:0] per,
                            input logic [2:0] ctrl, input int ncyc, input int setup);
        int len;
        int n;
        logic stp;
        logic ph;
        logic [15:0] l;
        if (setup == 1) begin
            cyc(1'b1, 2'd1, 32'd0, 1'b0, tag, 16'd0, 1'b0, 32'd0);
            cyc(1'b1, 2'd0, {16'd0, data}, 1'b0, tag, 16'd0, 1'b0, 32'd0);
            cyc(1'b1, 2'd2, {16'd0, per}, 1'b0, tag, 16'd0, 1'b0, 32'd0);
        end
        if (setup != 2) begin
            cyc(1'b1, 2'd1, {29'd0, ctrl}, 1'b0, tag, 16'd0, 1'b0, 32'd0);
        end
        len = 4 * ((per == 16'd0) ? 1 : int'(per));
        for (int k = 0; k < ncyc; k++) begin
            n = k / len;
            stp = ctrl[2] && ((k + 1) % len == 0);
            l = ctrl[2] ? exp_leds(data, ctrl[1:0], n) : 16'd0;
            ph = ctrl[2] && (ctrl[1:0] == 2'd1) && n[0];
            cyc(1'b0, 2'd3, 32'd0, 1'b1, tag, l, stp, {14'd0, ph, ctrl[2], l});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst.leds", {16'd0, leds_o}, 32'd0);
        chk("rst.step", {31'd0, step_o}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            addr_i = 2'(a);
            #1;
            chk($sformatf("rst.rdata%0d", a), rdata_o, 32'd0);
        end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        addr_i = 2'd3;

        run_mode("static", 16'h00F0, 16'd0, 3'h4, 12, 1);
        run_mode("rotl_p2", 16'h8001, 16'd2, 3'h6, 24, 1);
        run_mode("rotr_p0", 16'h0001, 16'd0, 3'h7, 12, 1);
        run_mode("mode_chg", 16'h0001, 16'd0, 3'h6, 12, 0);
        run_mode("blink", 16'hAAAA, 16'd1, 3'h5, 16, 1);
        run_mode("disable", 16'hAAAA, 16'd1, 3'h1, 12, 0);

        // DATA write landing on a step: step_o pulses, rotation is discarded, timing restarts.
        run_mode("pre_coll", 16'h0001, 16'd1, 3'h6, 3, 1);
        cyc(1'b1, 2'd0, 32'h0000_0010, 1'b1, "coll", 16'h0001, 1'b1, 32'h0000_0001);
        run_mode("post_coll", 16'h0010, 16'd1, 3'h6, 12, 2);

        // Asynchronous reset in the middle of a step cycle.
        run_mode("pre_rst", 16'h0001, 16'd1, 3'h6, 7, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst.leds", {16'd0, leds_o}, 32'd0);
        chk("arst.step", {31'd0, step_o}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            addr_i = 2'(a);
            #1;
            chk($sformatf("arst.rdata%0d", a), rdata_o, 32'd0);
        end
        @(posedge clk_i);
        #1;
        chk("arst_hold.leds", {16'd0, leds_o}, 32'd0);
        chk("arst_hold.step", {31'd0, step_o}, 32'd0);
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 2'd3, 32'd0, 1'b1, "post_rst", 16'd0, 1'b0, 32'd0);
        end
        run_mode("recover", 16'h00F0, 16'd0, 3'h4, 8, 1);

        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
